// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM states and program label addresses.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [PC_W-1:0] MAIN    = 8'd4;
  localparam logic [PC_W-1:0] LOOP    = 8'd16;
  localparam logic [PC_W-1:0] SUMA    = 8'd56;
  localparam logic [PC_W-1:0] SUMAAUX = 8'd80;
  localparam logic [PC_W-1:0] DONE    = 8'd112;
  localparam logic [PC_W-1:0] EXIT    = 8'd128;

endpackage

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// Next-PC select: sequential +4 (wrapping) or word-aligned jump target.
module pc_next_sel #(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] instr_pc,
  input  logic            senable,
  input  logic [PC_W-1:0] pc_salto,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] w_seq_pc;
  logic [PC_W-1:0] w_jump_pc;

  // Sum is truncated to PC_W bits, so the PC wraps modulo 2^PC_W.
  assign w_seq_pc  = instr_pc + PC_W'(4);
  assign w_jump_pc = {pc_salto[PC_W-1:2], 2'b00};
  assign next_pc   = senable ? w_jump_pc : w_seq_pc;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: holds the PC, fetches one word per req/ack handshake and holds it for the decoder.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int              N          = INSTR_W,
  parameter int              PC_W       = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_ADDR = '0,
  parameter logic [PC_W-1:0] EXIT_ADDR  = PC_W'(128)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            senable,
  input  logic [PC_W-1:0] pc_salto,
  input  logic            stall,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [N-1:0]    imem_data,
  output logic [N-1:0]    instruccion,
  output logic            instr_valid,
  output logic [PC_W-1:0] instr_pc,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output fetch_state_t    o_dbg_state
);

  // Handshake: imem_req stays high in FETCH until a rising edge samples imem_ack=1;
  // that edge captures imem_data. ack may coincide with the first req cycle.
  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_instr_pc;
  logic [N-1:0]    r_instr;
  logic            r_valid;
  logic            r_halted;
  logic [PC_W-1:0] w_next_pc;

  pc_next_sel #(.PC_W(PC_W)) u_pc_next_sel (
    .instr_pc (r_instr_pc),
    .senable  (senable),
    .pc_salto (pc_salto),
    .next_pc  (w_next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_ADDR;
      r_instr_pc <= '0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            r_instr    <= imem_data;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_state    <= HOLD;
          end
        end
        HOLD: begin
          // A stalled instruction is not consumed, so the decoder result is ignored.
          if (!stall) begin
            r_valid <= 1'b0;
            r_pc    <= w_next_pc;
            if (w_next_pc == EXIT_ADDR) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= FETCH;
            end
          end
        end
        HALT: begin
          r_valid  <= 1'b0;
          r_halted <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruccion = r_instr;
  assign instr_valid = r_valid;
  assign instr_pc    = r_instr_pc;
  assign halted      = r_halted;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: handshake timing, jumps, stall, exit halt, wrap and async reset.
module tb_fetch_pc_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        senable;
  logic [7:0]  pc_salto;
  logic        stall;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instruccion;
  logic        instr_valid;
  logic [7:0]  instr_pc;
  logic [7:0]  pc;
  logic        halted;
  fetch_state_t dbg_state;

  logic        w_rst_n;
  logic        w_imem_req;
  logic [7:0]  w_imem_addr;
  logic [31:0] w_imem_data;
  logic [31:0] w_instruccion;
  logic        w_instr_valid;
  logic [7:0]  w_instr_pc;
  logic [7:0]  w_pc;
  logic        w_halted;
  fetch_state_t w_dbg_state;

  int n_checks;
  int n_errors;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {16'hC0DE, a ^ 8'h5A, a};
  endfunction

  assign imem_data   = mem_word(imem_addr);
  assign w_imem_data = mem_word(w_imem_addr);

  fetch_pc_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .senable     (senable),
    .pc_salto    (pc_salto),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instruccion (instruccion),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .pc          (pc),
    .halted      (halted),
    .o_dbg_state (dbg_state)
  );

  fetch_pc_unit #(.RESET_ADDR(8'd252)) u_wrap (
    .clk         (clk),
    .rst_n       (w_rst_n),
    .senable     (1'b0),
    .pc_salto    (8'd0),
    .stall       (1'b0),
    .imem_req    (w_imem_req),
    .imem_addr   (w_imem_addr),
    .imem_ack    (1'b1),
    .imem_data   (w_imem_data),
    .instruccion (w_instruccion),
    .instr_valid (w_instr_valid),
    .instr_pc    (w_instr_pc),
    .pc          (w_pc),
    .halted      (w_halted),
    .o_dbg_state (w_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a fresh run: reset, release, step IDLE->FETCH.
  task automatic restart();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Checks the FETCH-state outputs for an expected address.
  task automatic chk_fetch(input string tag, input logic [7:0] a);
    chk({tag, "_req"},  imem_req, 1'b1);
    chk({tag, "_addr"}, imem_addr, a);
    chk({tag, "_vld"},  instr_valid, 1'b0);
  endtask

  task automatic chk_hold(input string tag, input logic [7:0] a);
    chk({tag, "_req"},  imem_req, 1'b0);
    chk({tag, "_vld"},  instr_valid, 1'b1);
    chk({tag, "_ipc"},  instr_pc, a);
    chk({tag, "_ins"},  instruccion, mem_word(a));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    w_rst_n  = 1'b0;
    senable  = 1'b0;
    pc_salto = 8'd0;
    stall    = 1'b0;
    imem_ack = 1'b1;
    tick();
    tick();

    // Reset values
    chk("rst_state", dbg_state, IDLE);
    chk("rst_pc",    pc, 8'd0);
    chk("rst_ipc",   instr_pc, 8'd0);
    chk("rst_ins",   instruccion, 32'd0);
    chk("rst_vld",   instr_valid, 1'b0);
    chk("rst_req",   imem_req, 1'b0);
    chk("rst_halt",  halted, 1'b0);
    chk("wrap_rst_pc", w_pc, 8'd252);

    // Release both; ack tied 1: fetch at 0,4,8 with valid every other cycle
    rst_n   = 1'b1;
    w_rst_n = 1'b1;
    tick();
    chk("idle_to_fetch", dbg_state, FETCH);
    chk_fetch("f0", 8'd0);
    chk("wrap_f0_addr", w_imem_addr, 8'd252);
    tick();
    chk_hold("h0", 8'd0);
    chk("wrap_h0_ipc", w_instr_pc, 8'd252);
    tick();
    chk_fetch("f4", 8'd4);
    chk("wrap_f1_addr", w_imem_addr, 8'd0);
    chk("wrap_f1_req", w_imem_req, 1'b1);
    tick();
    chk_hold("h4", 8'd4);
    chk("wrap_h1_ipc", w_instr_pc, 8'd0);
    tick();
    chk_fetch("f8", 8'd8);
    tick();
    chk_hold("h8", 8'd8);

    // Memory latency 3 at address 4
    restart();
    tick();
    chk_hold("lat_h0", 8'd0);
    imem_ack = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_fetch("lat_wait", 8'd4);
      chk("lat_pc", pc, 8'd4);
      chk("lat_ins_old", instruccion, mem_word(8'd0));
      imem_ack = (i == 2);
      tick();
    end
    chk_hold("lat_h4", 8'd4);

    // Jump from 4 to SUMA, then from SUMA with target 18 -> aligned 16
    imem_ack = 1'b1;
    senable  = 1'b1;
    pc_salto = SUMA;
    tick();
    chk_fetch("j_f56", 8'd56);
    tick();
    chk_hold("j_h56", 8'd56);
    pc_salto = 8'd18;
    tick();
    chk_fetch("j_f16", 8'd16);
    chk("j_pc16", pc, 8'd16);
    senable = 1'b0;
    tick();
    chk_hold("s_h16", 8'd16);

    // Stall 5 cycles with senable toggling
    stall    = 1'b1;
    pc_salto = 8'd40;
    for (int i = 0; i < 5; i++) begin
      senable = i[0];
      tick();
      chk_hold("stall", 8'd16);
      chk("stall_pc", pc, 8'd16);
    end
    stall   = 1'b0;
    senable = 1'b0;
    tick();
    chk_fetch("stall_rel", 8'd20);
    tick();
    chk_hold("h20", 8'd20);

    // Misaligned jump to 122 -> 120, then sequential 124 -> 128 halts
    senable  = 1'b1;
    pc_salto = 8'd122;
    tick();
    chk_fetch("f120", 8'd120);
    senable = 1'b0;
    tick();
    chk_hold("h120", 8'd120);
    tick();
    chk_fetch("f124", 8'd124);
    tick();
    chk_hold("h124", 8'd124);
    tick();
    chk("exit_state", dbg_state, HALT);
    chk("exit_halt",  halted, 1'b1);
    chk("exit_pc",    pc, 8'd128);
    chk("exit_req",   imem_req, 1'b0);
    chk("exit_vld",   instr_valid, 1'b0);
    senable  = 1'b1;
    pc_salto = 8'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_req",  imem_req, 1'b0);
      chk("halt_stay", halted, 1'b1);
    end
    senable = 1'b0;

    // Jump straight to EXIT halts
    restart();
    tick();
    chk_hold("je_h0", 8'd0);
    senable  = 1'b1;
    pc_salto = EXIT;
    tick();
    chk("je_halt", halted, 1'b1);
    chk("je_req",  imem_req, 1'b0);
    chk("je_pc",   pc, 8'd128);
    senable = 1'b0;

    // Async reset while waiting for ack
    restart();
    tick();
    chk_hold("ar_h0", 8'd0);
    imem_ack = 1'b0;
    tick();
    tick();
    chk_fetch("ar_wait", 8'd4);
    rst_n = 1'b0;
    #1;
    chk("ar_pc",    pc, 8'd0);
    chk("ar_req",   imem_req, 1'b0);
    chk("ar_vld",   instr_valid, 1'b0);
    chk("ar_state", dbg_state, IDLE);
    chk("ar_ins",   instruccion, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
